// File: rtl/prach_sched_pkg.sv
// prach_sched_pkg
//   Shared definitions for the PRACH channel scheduler:
//   - sched_state_e : scheduler FSM states (SCHED_IDLE until the first sync, then SCHED_RUN)
//   - CHN_W         : width of the channel tag presented to the reshape datapath
//   - LANES         : number of sample lanes per channel
//   - lane_t/sample_t : default 16-bit three-lane sample type
package prach_sched_pkg;

  typedef enum logic {
    SCHED_IDLE = 1'b0,
    SCHED_RUN  = 1'b1
  } sched_state_e;

  localparam int unsigned CHN_W  = 8;
  localparam int unsigned LANES  = 3;
  localparam int unsigned LANE_W = 16;

  typedef logic [LANE_W-1:0] lane_t;
  typedef lane_t [LANES-1:0] sample_t;

endpackage

// File: rtl/prach_rr_arb.sv
// prach_rr_arb
//   Combinational round-robin priority select. Grants the first set bit of
//   req at or after ptr, scanning upward and wrapping NUM_CH-1 -> 0.
//   Ports:
//     req     in  NUM_CH  request vector
//     ptr     in  PW      starting index of the scan
//     gnt_v   out 1       a request was found
//     gnt_idx out PW      granted index (0 when gnt_v=0)
module prach_rr_arb #(
  parameter  int unsigned NUM_CH = 8,
  localparam int unsigned PW     = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PW-1:0]     ptr,
  output logic              gnt_v,
  output logic [PW-1:0]     gnt_idx
);

  localparam logic [PW:0] NCH = (PW+1)'(NUM_CH);

  logic [PW:0] w_idx;

  always_comb begin
    gnt_v   = 1'b0;
    gnt_idx = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      w_idx = {1'b0, ptr} + (PW+1)'(k);
      if (w_idx >= NCH) w_idx = w_idx - NCH;
      if (!gnt_v && req[w_idx[PW-1:0]]) begin
        gnt_v   = 1'b1;
        gnt_idx = w_idx[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/prach_chn_sched.sv
// prach_chn_sched
//   Round-robin scheduler multiplexing NUM_CH three-lane sample streams onto
//   one shared datapath input. Each channel owns a one-deep holding register
//   behind a valid/ready handshake; one held sample is issued per cycle,
//   tagged with its channel number. sync_in re-arms the schedule, latches
//   ch_en and flushes held samples into the saturating drop counter.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     ch_en     in  NUM_CH enable mask, sampled only on sync_in
//     req_dq    in  DW     per-channel three-lane sample
//     req_valid in  NUM_CH sample offered
//     req_ready out NUM_CH holding register free and channel active
//     sync_in   in  1      frame boundary pulse
//     dout_dq   out DW x3  granted sample
//     dout_dv   out 1      sample valid
//     dout_chn  out 8      granted channel index
//     sync_out  out 1      sync aligned to the first slot of the new frame
//     drop_cnt  out 16     saturating count of discarded samples
module prach_chn_sched
  import prach_sched_pkg::*;
#(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned DW     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [DW-1:0]     req_dq [NUM_CH][LANES],
  input  logic [NUM_CH-1:0] req_valid,
  output logic [NUM_CH-1:0] req_ready,
  input  logic              sync_in,
  output logic [DW-1:0]     dout_dq [LANES],
  output logic              dout_dv,
  output logic [CHN_W-1:0]  dout_chn,
  output logic              sync_out,
  output logic [15:0]       drop_cnt
);

  localparam int unsigned PW = $clog2(NUM_CH);

  sched_state_e               r_state;
  logic [NUM_CH-1:0]          r_en_active;
  logic [PW-1:0]              r_ptr;
  logic [NUM_CH-1:0]          r_hold_v;
  logic [LANES-1:0][DW-1:0]   r_hold_dq [NUM_CH];
  logic [LANES-1:0][DW-1:0]   r_dout_dq;
  logic                       r_dout_dv;
  logic [CHN_W-1:0]           r_dout_chn;
  logic                       r_sync_out;
  logic [15:0]                r_drop;

  logic                       w_run;
  logic [NUM_CH-1:0]          w_xfer;
  logic [NUM_CH-1:0]          w_elig;
  logic                       w_gnt_v;
  logic [PW-1:0]              w_gnt_idx;
  logic [NUM_CH-1:0]          w_gnt_mask;
  logic [PW-1:0]              w_ptr_next;
  logic [15:0]                w_drop_add;
  logic [16:0]                w_drop_sum;
  logic [15:0]                w_drop_next;

  assign w_run     = (r_state == SCHED_RUN);
  assign req_ready = {NUM_CH{w_run}} & r_en_active & ~r_hold_v;
  assign w_xfer    = req_valid & req_ready;
  assign w_elig    = {NUM_CH{w_run}} & r_hold_v & r_en_active;

  prach_rr_arb #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req     (w_elig),
    .ptr     (r_ptr),
    .gnt_v   (w_gnt_v),
    .gnt_idx (w_gnt_idx)
  );

  assign w_gnt_mask = w_gnt_v ? (NUM_CH'(1) << w_gnt_idx) : '0;
  assign w_ptr_next = (w_gnt_idx == PW'(NUM_CH-1)) ? '0 : w_gnt_idx + PW'(1);

  // Samples lost on a sync: everything held plus anything accepted that same cycle.
  always_comb begin
    w_drop_add = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_drop_add = w_drop_add + 16'(r_hold_v[i]) + 16'(w_xfer[i]);
    end
    w_drop_sum  = {1'b0, r_drop} + {1'b0, w_drop_add};
    w_drop_next = w_drop_sum[16] ? '1 : w_drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= SCHED_IDLE;
      r_en_active <= '0;
      r_ptr       <= '0;
      r_hold_v    <= '0;
      r_dout_dq   <= '0;
      r_dout_dv   <= 1'b0;
      r_dout_chn  <= '0;
      r_sync_out  <= 1'b0;
      r_drop      <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) r_hold_dq[i] <= '0;
    end else begin
      r_sync_out <= sync_in;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (w_xfer[i]) begin
          for (int unsigned k = 0; k < LANES; k++) r_hold_dq[i][k] <= req_dq[i][k];
        end
      end
      if (sync_in) begin
        r_state     <= SCHED_RUN;
        r_en_active <= ch_en;
        r_ptr       <= '0;
        r_hold_v    <= '0;
        r_dout_dv   <= 1'b0;
        r_drop      <= w_drop_next;
      end else begin
        // ready excludes held channels, so a set and a grant-clear never hit the same bit
        r_hold_v  <= (r_hold_v | w_xfer) & ~w_gnt_mask;
        r_dout_dv <= w_gnt_v;
        if (w_gnt_v) begin
          r_dout_dq  <= r_hold_dq[w_gnt_idx];
          r_dout_chn <= CHN_W'(w_gnt_idx);
          r_ptr      <= w_ptr_next;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) dout_dq[k] = r_dout_dq[k];
  end

  assign dout_dv  = r_dout_dv;
  assign dout_chn = r_dout_chn;
  assign sync_out = r_sync_out;
  assign drop_cnt = r_drop;

endmodule

// File: doc/prach_chn_sched.md
# prach_chn_sched

Round-robin channel scheduler that time-multiplexes up to NUM_CH per-channel PRACH sample streams onto the single shared reshape datapath input (three 16-bit lanes plus `din_dv`/`din_chn`/`sync_in`). Each channel has a one-deep holding register with a valid/ready handshake. A fair round-robin grant issues at most one sample per cycle, tagged with its channel number. The frame sync re-arms the schedule, latches the channel-enable configuration and flushes stale samples.

## Interface
Parameters:
- `NUM_CH`, 8, number of requesting channels (2..256)
- `DW`, 16, lane width

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `ch_en`  in  NUM_CH  channel enable mask; sampled only on `sync_in`
- `req_dq[NUM_CH][3]`  in  DW  per-channel three-lane sample
- `req_valid[NUM_CH]`  in  1  sample offered
- `req_ready[NUM_CH]`  out  1  holding register free and channel active
- `sync_in`  in  1  frame-boundary pulse
- `dout_dq[3]`  out  DW  granted sample, to reshape `din_dq`
- `dout_dv`  out  1  sample valid
- `dout_chn`  out  8  channel index of granted sample, zero-extended
- `sync_out`  out  1  sync to datapath, aligned to first slot of new frame
- `drop_cnt`  out  16  saturating count of discarded samples

Clocking and reset:
- One clock.
- Reset is synchronous and active-high.

## Operation
- States:
  - IDLE (after reset): `en_active`=0, all `req_ready`=0, no grants.
  - IDLE → RUN on the first `sync_in`.
  - RUN → RUN on every further `sync_in` (re-arm). Only `rst` returns to IDLE.
- On `sync_in` (any state):
  - `en_active` ← `ch_en`, `ptr` ← 0.
  - All holding registers are cleared.
  - Nothing is issued that cycle.
- Handshake:
  - `req_ready[i]` = RUN & `en_active[i]` & !`hold_v[i]`.
  - A transfer occurs when `req_valid[i]` & `req_ready[i]`. `hold_v[i]` is set the next cycle.
  - `req_valid` may be held across cycles; data must be stable while valid & !ready.
- Arbitration (RUN, no `sync_in`):
  - Eligible set = `hold_v` & `en_active`.
  - Grant the first eligible index at or after `ptr`, scanning upward and wrapping NUM_CH-1 → 0.
  - On grant g: `hold_v[g]` is cleared the same edge, `ptr` ← (g+1) mod NUM_CH, and the sample is registered to the output.
  - No eligible channel: `dout_dv`=0, `ptr` unchanged.
- `dout_dq`/`dout_chn` hold their last values when `dout_dv`=0.
- Drops, counted in `drop_cnt`:
  - On a `sync_in` cycle, add popcount(`hold_v`) plus the number of handshakes completing in that same cycle.
  - `drop_cnt` saturates at 0xFFFF and clears only on `rst`.
- Disabled channels: `ch_en` changes between syncs have no effect. A channel disabled at sync never asserts ready.

## Timing
- Reset values: `dout_dq`=0, `dout_dv`=0, `dout_chn`=0, `sync_out`=0, `req_ready`=0, `drop_cnt`=0, `ptr`=0, state IDLE.
- Latency: handshake at cycle t → `hold_v` at t+1 → granted at t+1 → `dout_dv` at t+2.
- Per-channel throughput is 1 sample / 2 cycles. Aggregate throughput is 1 sample / cycle with ≥2 active channels.
- `sync_in` at t:
  - `sync_out`=1 and `dout_dv`=0 at t+1.
  - `req_ready` reflects the new `en_active` at t+1.
  - Earliest new output is at t+3.
- Back-to-back `sync_in` cycles each re-arm and each produce a `sync_out` pulse one cycle later.
- `rst` mid-frame: all state returns to reset values on the next edge; pending samples are lost and not counted.

## Structure
- Package `prach_sched_pkg` holds:
  - state enum (`SCHED_IDLE`, `SCHED_RUN`)
  - `CHN_W`=8 and lane count 3
  - the three-lane sample typedef
- Sub-module `prach_rr_arb`, parameterized NUM_CH:
  - combinational round-robin priority select from (`req` vector, `ptr`) to (`gnt_v`, `gnt_idx`)
  - `ptr` register kept in the top level
- Top level holds the holding registers, FSM, output register and drop counter.

## Test plan
- **Reset/idle:** `rst`, then `req_valid`=all 1 without sync → `req_ready`=0, `dout_dv`=0 for 20 cycles, `drop_cnt`=0.
- **Fair rotation:** NUM_CH=8, `ch_en`=0xFF, sync, then all channels always valid → `dout_chn` = 0,1,…,7,0,… every cycle after the initial fill. Each channel's samples appear in order; channels 0..7 each get exactly 2 grants in 16 consecutive valid cycles.
- **Sparse/wrap:** `ch_en`=0x81, only channels 7 and 0 valid, `ptr`=7 → grants alternate 7,0,7,0. Channel 3 valid but disabled → ready stays 0.
- **Sync flush:** channels 2 and 5 holding, plus a handshake on channel 6 in the sync cycle → `drop_cnt` +3, `sync_out`=1 one cycle later, then the first grant goes to the lowest eligible index from 0.
- **Config latch:** change `ch_en` 0x0F→0xF0 mid-frame → no effect until the next `sync_in`; after it, only channels 4–7 ready.
- **Saturation/latency:** force 0x10000 drops → `drop_cnt` holds 0xFFFF. Single isolated handshake → `dout_dv` exactly 2 cycles later with matching data and `dout_chn`.
